// File: rtl/proc_sequencer.sv
// -----------------------------------------------------------------------------
// proc_sequencer
//
// Multi-cycle control unit for the 64-word semi-processor datapath.
// Fetches 9-bit instructions from a synchronous instruction memory, decodes
// them and drives one-cycle control strobes into the accumulator/ALU/LED
// datapath. Only PC, IR and FSM state live here; all data state lives in the
// datapath.
//
// Instruction format: opcode [8:6], arg [5:0].
// Each instruction takes three cycles: FETCH, DECODE, EXEC.
//
// Optional feature macro: PROC_SEQ_STEP_EN
//   defined   : a rising edge on i_step in IDLE (with i_run low) executes
//               exactly one instruction and then returns to IDLE.
//   undefined : i_step is ignored and IDLE is left only on i_run.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_run        free-run enable (level), sampled in IDLE and at end of EXEC
//   i_step       single-step request, rising edge detected internally
//   i_imem_rdata instruction memory read data (valid 1 cycle after address)
//   i_zero       accumulator==0 flag, sampled on the edge ending EXEC
//   o_imem_addr  current PC
//   o_operand    IR arg field (immediate / branch target)
//   o_alu_op     00 pass, 01 add, 10 sub; valid during EXEC
//   o_acc_sel    0 ALU result, 1 switch input
//   o_acc_we     accumulator write strobe (EXEC only)
//   o_led_we     LED register write strobe (EXEC only)
//   o_busy       high in FETCH/DECODE/EXEC
//   o_halted     high in HALT (sticky until reset)
// -----------------------------------------------------------------------------
module proc_sequencer #(
  parameter int AW = 6,
  parameter int IW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_step,
  input  logic [IW-1:0] i_imem_rdata,
  input  logic          i_zero,
  output logic [AW-1:0] o_imem_addr,
  output logic [5:0]    o_operand,
  output logic [1:0]    o_alu_op,
  output logic          o_acc_sel,
  output logic          o_acc_we,
  output logic          o_led_we,
  output logic          o_busy,
  output logic          o_halted
);

  localparam logic [2:0] OP_LDSW = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUBI = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_JZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic [1:0]    r_alu_op;
  logic          r_acc_sel;
  logic          r_acc_we;
  logic          r_led_we;
  logic          r_busy;
  logic          r_halted;
  logic          r_step_txn;   // current instruction was started by a step edge

  logic [2:0]    w_dec_op;
  logic [2:0]    w_ir_op;
  logic [AW-1:0] w_arg;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_next_pc;
  logic          w_step_start;
  logic [1:0]    w_alu_op;
  logic          w_acc_sel;
  logic          w_acc_we;
  logic          w_led_we;

  assign w_dec_op = i_imem_rdata[8:6];
  assign w_ir_op  = r_ir[8:6];
  assign w_arg    = r_ir[AW-1:0];
  // Natural wrap of the AW-bit adder gives 63 -> 0 with no flag.
  assign w_pc_inc = r_pc + {{(AW-1){1'b0}}, 1'b1};

`ifdef PROC_SEQ_STEP_EN
  logic r_step_prev;

  // One-flop history of i_step for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= i_step;
    end
  end

  assign w_step_start = i_step & ~r_step_prev;
`else
  logic w_unused_step;
  assign w_unused_step = i_step;
  assign w_step_start  = 1'b0;
`endif

  // Decode the instruction arriving from memory into next-EXEC strobes.
  always_comb begin
    w_alu_op  = 2'b00;
    w_acc_sel = 1'b0;
    w_acc_we  = 1'b0;
    w_led_we  = 1'b0;
    case (w_dec_op)
      OP_LDSW: begin
        w_acc_we  = 1'b1;
        w_acc_sel = 1'b1;
      end
      OP_ADDI: begin
        w_acc_we = 1'b1;
        w_alu_op = 2'b01;
      end
      OP_SUBI: begin
        w_acc_we = 1'b1;
        w_alu_op = 2'b10;
      end
      OP_OUT: begin
        w_led_we = 1'b1;
      end
      default: begin
        w_alu_op  = 2'b00;
        w_acc_sel = 1'b0;
        w_acc_we  = 1'b0;
        w_led_we  = 1'b0;
      end
    endcase
  end

  // PC value taken at the end of EXEC (JZ uses i_zero from that same edge).
  always_comb begin
    w_next_pc = w_pc_inc;
    if (w_ir_op == OP_JMP) begin
      w_next_pc = w_arg;
    end else if ((w_ir_op == OP_JZ) && i_zero) begin
      w_next_pc = w_arg;
    end else begin
      w_next_pc = w_pc_inc;
    end
  end

  // Sequencer FSM with registered strobes and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= {AW{1'b0}};
      r_ir       <= {IW{1'b0}};
      r_alu_op   <= 2'b00;
      r_acc_sel  <= 1'b0;
      r_acc_we   <= 1'b0;
      r_led_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_step_txn <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run || w_step_start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            // run wins when both are present; only a pure step is one-shot
            r_step_txn <= ~i_run;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_state   <= S_EXEC;
          r_ir      <= i_imem_rdata;
          r_alu_op  <= w_alu_op;
          r_acc_sel <= w_acc_sel;
          r_acc_we  <= w_acc_we;
          r_led_we  <= w_led_we;
        end
        S_EXEC: begin
          r_pc      <= w_next_pc;
          r_alu_op  <= 2'b00;
          r_acc_sel <= 1'b0;
          r_acc_we  <= 1'b0;
          r_led_we  <= 1'b0;
          if (w_ir_op == OP_HALT) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (i_run && !r_step_txn) begin
            r_state <= S_FETCH;
          end else begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_step_txn <= 1'b0;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_addr = r_pc;
  assign o_operand   = r_ir[5:0];
  assign o_alu_op    = r_alu_op;
  assign o_acc_sel   = r_acc_sel;
  assign o_acc_we    = r_acc_we;
  assign o_led_we    = r_led_we;
  assign o_busy      = r_busy;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_proc_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for proc_sequencer: fixed program table, hand-written
// branch / step / run-drop / reset sequences, and randomized stimulus checked
// against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_proc_sequencer;

`ifdef PROC_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, run, step, zero;
  logic [8:0] imem_rdata;
  logic [5:0] imem_addr;
  logic [5:0] operand;
  logic [1:0] alu_op;
  logic       acc_sel, acc_we, led_we, busy, halted;

  logic [8:0] mem [64];

  int errors = 0;
  int checks = 0;

  // reference model state (instruction-level)
  int         m_phase;   // 0 idle, 1 fetch, 2 decode, 3 exec, 4 halt
  logic [5:0] m_pc;
  logic [5:0] m_arg;
  logic [2:0] m_op;
  bit         m_prev;
  bit         m_smode;

  typedef struct {
    bit run;
    bit zero;
    int busy;
    int halted;
    int addr;      // -1: not checked
    int acc_we;
    int acc_sel;
    int alu_op;
    int led_we;
    int operand;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  // synchronous instruction memory
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  proc_sequencer #(.AW(6), .IW(9)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step),
    .i_imem_rdata(imem_rdata), .i_zero(zero),
    .o_imem_addr(imem_addr), .o_operand(operand), .o_alu_op(alu_op),
    .o_acc_sel(acc_sel), .o_acc_we(acc_we), .o_led_we(led_we),
    .o_busy(busy), .o_halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {acc_we, acc_sel, alu_op[1:0], led_we} expected for an opcode in EXEC
  function automatic logic [4:0] exp_strobes(input int ph, input logic [2:0] op);
    if (ph != 3) return 5'b00000;
    case (op)
      3'd1:    return 5'b11000;
      3'd2:    return 5'b10010;
      3'd3:    return 5'b10100;
      3'd4:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit rn, input bit st, input bit z);
    bit rise;
    logic [8:0] w;
    if (r) begin
      m_phase = 0; m_pc = 6'd0; m_arg = 6'd0; m_op = 3'd0;
      m_prev = 1'b0; m_smode = 1'b0;
    end else begin
      rise   = STEP_EN && st && !m_prev;
      m_prev = st;
      case (m_phase)
        0: if (rn || rise) begin m_phase = 1; m_smode = !rn; end
        1: m_phase = 2;
        2: begin
          w = mem[m_pc];
          m_op = w[8:6]; m_arg = w[5:0]; m_phase = 3;
        end
        3: begin
          if (m_op == 3'd5 || (m_op == 3'd6 && z)) m_pc = m_arg;
          else m_pc = m_pc + 6'd1;
          if (m_op == 3'd7) m_phase = 4;
          else if (rn && !m_smode) m_phase = 1;
          else m_phase = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    logic [4:0] s;
    s = exp_strobes(m_phase, m_op);
    chk("busy", busy, (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    chk("halted", halted, (m_phase == 4) ? 1 : 0);
    if (m_phase != 4) chk("imem_addr", imem_addr, m_pc);
    chk("operand", operand, m_arg);
    chk("acc_we", acc_we, s[4]);
    chk("acc_sel", acc_sel, s[3]);
    chk("alu_op", alu_op, s[2:1]);
    chk("led_we", led_we, s[0]);
  endtask

  // drive one cycle of inputs, advance model, sample #1 after the edge
  task automatic tick(input bit r, input bit rn, input bit st, input bit z);
    rst = r; run = rn; step = st; zero = z;
    model_edge(r, rn, st, z);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 9'd0;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; run = 1'b0; step = 1'b0; zero = 1'b0;
    clear_mem();
    model_edge(1'b1, 1'b0, 1'b0, 1'b0);

    // program table: {run, zero, busy, halted, addr, acc_we, acc_sel, alu_op, led_we, operand}
    // entry i = inputs during cycle i, outputs expected in cycle i+1
    tbl[0]  = '{1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0,  0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 0,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 0,  1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0,  1, 1, 0, 1, 0, 5};
    tbl[6]  = '{1, 0, 1, 0,  2, 0, 0, 0, 0, 5};
    tbl[7]  = '{1, 0, 1, 0,  2, 0, 0, 0, 0, 5};
    tbl[8]  = '{1, 0, 1, 0,  2, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 0,  3, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 0,  3, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 0,  3, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 1, -1, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 1, -1, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 1, -1, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 1, -1, 0, 0, 0, 0, 0};

    mem[0] = {3'd1, 6'd0};   // LDSW
    mem[1] = {3'd2, 6'd5};   // ADDI 5
    mem[2] = {3'd4, 6'd0};   // OUT
    mem[3] = {3'd7, 6'd0};   // HALT

    // reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_halted", halted, 0);
    chk("reset_strobes", {acc_we, led_we, acc_sel, alu_op, operand}, 0);

    for (int i = 0; i < 16; i++) begin
      tick(1'b0, tbl[i].run, 1'b0, tbl[i].zero);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].halted);
      if (tbl[i].addr >= 0) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_acc_we", i), acc_we, tbl[i].acc_we);
      chk($sformatf("tbl%0d_acc_sel", i), acc_sel, tbl[i].acc_sel);
      chk($sformatf("tbl%0d_alu_op", i), alu_op, tbl[i].alu_op);
      chk($sformatf("tbl%0d_led_we", i), led_we, tbl[i].led_we);
      chk($sformatf("tbl%0d_operand", i), operand, tbl[i].operand);
    end

    // reset out of HALT
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("halt_reset_halted", halted, 0);
    chk("halt_reset_addr", imem_addr, 0);

    // branches: JZ taken, JMP, JZ not taken at PC=4, JMP 63 + NOP wraps
    clear_mem();
    mem[0]  = {3'd6, 6'd10};
    mem[10] = {3'd5, 6'd4};
    mem[4]  = {3'd6, 6'd10};
    mem[5]  = {3'd5, 6'd63};
    mem[63] = {3'd0, 6'd0};
    do_reset();
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("jz_taken_addr", imem_addr, 10);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("jmp_addr", imem_addr, 4);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("jz_not_taken_addr", imem_addr, 5);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("jmp63_addr", imem_addr, 63);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_idle", busy, 0);

    // run dropped during DECODE: EXEC still strobes, then IDLE with PC+1
    clear_mem();
    mem[0] = {3'd2, 6'd3};
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rundrop_acc_we", acc_we, 1);
    chk("rundrop_alu_op", alu_op, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rundrop_busy", busy, 0);
    chk("rundrop_addr", imem_addr, 1);

    // reset in the middle of EXEC of ADDI
    do_reset();
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
    chk("midexec_acc_we_before", acc_we, 1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midexec_acc_we", acc_we, 0);
    chk("midexec_busy", busy, 0);
    chk("midexec_addr", imem_addr, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);

    // single step with a second pulse while busy
    clear_mem();
    do_reset();
    busy_cnt = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0); busy_cnt += busy;
    tick(1'b0, 1'b0, 1'b0, 1'b0); busy_cnt += busy;
    tick(1'b0, 1'b0, 1'b1, 1'b0); busy_cnt += busy;
    tick(1'b0, 1'b0, 1'b0, 1'b0); busy_cnt += busy;
    tick(1'b0, 1'b0, 1'b0, 1'b0); busy_cnt += busy;
    tick(1'b0, 1'b0, 1'b0, 1'b0); busy_cnt += busy;
    chk("step_busy_cycles", busy_cnt, STEP_EN ? 3 : 0);
    chk("step_addr", imem_addr, STEP_EN ? 1 : 0);
    chk("step_idle", busy, 0);

    // randomized program and stimulus against the model
    for (int i = 0; i < 64; i++) mem[i] = 9'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0) || (m_phase == 4 && $urandom_range(0, 3) == 0);
      tick(r, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
